// File: rtl/gate_request_ctrl_if.sv
// Signal bundle between the gate request stage and its surroundings: raw buttons and
// occupancy feedback in, clean single-cycle request pulses out to the parking FSM.
interface gate_request_ctrl_if;
    logic       entry_btn;
    logic       exit_btn;
    logic [1:0] exit_sel;
    logic [3:0] spots;
    logic [2:0] capacity;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic       reject;
    logic       busy;

    // master: the request controller itself
    modport master (
        input  entry_btn, exit_btn, exit_sel, spots, capacity,
        output entry_signal, exit_signal, exit_slot, reject, busy
    );

    // slave: buttons, occupancy source and the downstream FSM
    modport slave (
        output entry_btn, exit_btn, exit_sel, spots, capacity,
        input  entry_signal, exit_signal, exit_slot, reject, busy
    );
endinterface

// File: rtl/gate_request_ctrl.sv
// Gate request front end: synchronise, debounce and edge-detect the entry/exit buttons,
// arbitrate, validate against occupancy, and emit spaced pulses. Optional: ALTERNATE_PRIO_EN.
module gate_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 3
) (
    input logic               clk,
    input logic               reset,
    gate_request_ctrl_if.master bus
);

    localparam int unsigned    CNT_W    = 8;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     GAP_LOAD = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

`ifdef ALTERNATE_PRIO_EN
    typedef enum logic {
        WIN_ENTRY = 1'b0,
        WIN_EXIT  = 1'b1
    } winner_e;

    winner_e last_winner_q, last_winner_d;
`endif

    // Bit 0 is the entry button, bit 1 the exit button throughout.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            level_q, level_d;
    logic [1:0]            level_prev_q, level_prev_d;
    logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]            rise;

    logic [1:0]            pend_q, pend_d;
    logic [1:0]            pend_slot_q, pend_slot_d;
    logic [1:0]            clear;

    state_e                state_q, state_d;
    logic                  sel_exit_q, sel_exit_d;
    logic [1:0]            exit_slot_q, exit_slot_d;
    logic [3:0]            hold_q, hold_d;

    logic                  pick_exit;
    logic [2:0]            cap_eff;
    logic                  entry_pulse, exit_pulse, reject_pulse;

    assign btn_raw = {bus.exit_btn, bus.entry_btn};

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        deb_cnt_d    = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                level_d[i]   = ~level_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign rise = level_q & ~level_prev_q;

    // ------------------------------------------------------------------
    // Pending requests; a press on a flag being cleared this cycle survives
    // ------------------------------------------------------------------
    always_comb begin
        pend_slot_d = pend_slot_q;
        for (int i = 0; i < 2; i++) begin
            pend_d[i] = clear[i] ? rise[i] : (pend_q[i] | rise[i]);
        end
        if (rise[1] && (!pend_q[1] || clear[1])) begin
            pend_slot_d = bus.exit_sel;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: exit wins ties unless alternating priority is built in
    // ------------------------------------------------------------------
    always_comb begin
        pick_exit = pend_q[1];
`ifdef ALTERNATE_PRIO_EN
        if (pend_q == 2'b11) begin
            pick_exit = (last_winner_q == WIN_ENTRY);
        end
`endif
    end

    assign cap_eff = (bus.capacity > 3'd4) ? 3'd4 : bus.capacity;

    // ------------------------------------------------------------------
    // Request FSM: IDLE -> ISSUE -> HOLD -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_exit_d   = sel_exit_q;
        exit_slot_d  = exit_slot_q;
        hold_d       = hold_q;
        clear        = 2'b00;
        entry_pulse  = 1'b0;
        exit_pulse   = 1'b0;
        reject_pulse = 1'b0;
`ifdef ALTERNATE_PRIO_EN
        last_winner_d = last_winner_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d    = S_ISSUE;
                    sel_exit_d = pick_exit;
                    if (pick_exit) begin
                        exit_slot_d = pend_slot_q;
                    end
`ifdef ALTERNATE_PRIO_EN
                    if (&pend_q) begin
                        last_winner_d = pick_exit ? WIN_EXIT : WIN_ENTRY;
                    end
`endif
                end
            end
            S_ISSUE: begin
                clear[sel_exit_q] = 1'b1;
                hold_d            = GAP_LOAD;
                state_d           = S_HOLD;
                // Occupancy is judged on the values present in this very cycle.
                if (sel_exit_q) begin
                    if (bus.spots[pend_slot_q]) exit_pulse   = 1'b1;
                    else                        reject_pulse = 1'b1;
                end else begin
                    if (cap_eff != 3'd0)        entry_pulse  = 1'b1;
                    else                        reject_pulse = 1'b1;
                end
            end
            S_HOLD: begin
                hold_d = hold_q - 4'd1;
                if (hold_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            level_q       <= '0;
            level_prev_q  <= '0;
            deb_cnt_q     <= '0;
            pend_q        <= '0;
            pend_slot_q   <= '0;
            state_q       <= S_IDLE;
            sel_exit_q    <= 1'b0;
            exit_slot_q   <= '0;
            hold_q        <= '0;
`ifdef ALTERNATE_PRIO_EN
            last_winner_q <= WIN_ENTRY;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            level_prev_q  <= level_prev_d;
            deb_cnt_q     <= deb_cnt_d;
            pend_q        <= pend_d;
            pend_slot_q   <= pend_slot_d;
            state_q       <= state_d;
            sel_exit_q    <= sel_exit_d;
            exit_slot_q   <= exit_slot_d;
            hold_q        <= hold_d;
`ifdef ALTERNATE_PRIO_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign bus.entry_signal = entry_pulse;
    assign bus.exit_signal  = exit_pulse;
    assign bus.reject       = reject_pulse;
    assign bus.exit_slot    = exit_slot_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_request_ctrl.sv
// Self-checking bench for gate_request_ctrl: vector table, timing sequences and a
// randomized run against a timestamp-based reference model.
module tb_gate_request_ctrl;

    localparam int DEB = 4;
    localparam int GAP = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    gate_request_ctrl_if bus ();

    gate_request_ctrl #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pipeline delay as a sample history, request timing
    // as cycle timestamps rather than a state register.
    // ------------------------------------------------------------------
    logic [1:0] m_hist [$];
    logic [1:0] m_level, m_rose, m_pend, m_pend_slot, m_slot;
    int         m_run [2];
    bit         m_issuing, m_chose_exit, m_last_exit;
    int         m_cyc, m_hold_end;

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(2'b00);
        m_hist.push_back(2'b00);
        m_level = '0; m_rose = '0; m_pend = '0; m_pend_slot = '0; m_slot = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_issuing = 0; m_chose_exit = 0; m_last_exit = 0;
        m_cyc = 0; m_hold_end = 0;
    endtask

    task automatic model_step();
        logic [1:0] seen, rise, clr, old_pend;
        int n;
        bit was_idle;
        seen = m_hist.pop_front();
        m_hist.push_back({bus.exit_btn, bus.entry_btn});
        rise = m_rose; old_pend = m_pend; clr = '0; n = m_cyc + 1;
        was_idle = !m_issuing && (m_cyc >= m_hold_end);
        if (m_issuing) begin
            clr[int'(m_chose_exit)] = 1'b1;
            m_issuing  = 0;
            m_hold_end = n + GAP;
        end else if (was_idle && old_pend != 2'b00) begin
            if (old_pend == 2'b11) begin
`ifdef ALTERNATE_PRIO_EN
                m_chose_exit = !m_last_exit;
                m_last_exit  = m_chose_exit;
`else
                m_chose_exit = 1;
`endif
            end else begin
                m_chose_exit = old_pend[1];
            end
            m_issuing = 1;
            if (m_chose_exit) m_slot = m_pend_slot;
        end
        for (int i = 0; i < 2; i++) m_pend[i] = clr[i] ? rise[i] : (old_pend[i] | rise[i]);
        if (rise[1] && (!old_pend[1] || clr[1])) m_pend_slot = bus.exit_sel;
        for (int i = 0; i < 2; i++) begin
            m_rose[i] = 1'b0;
            if (seen[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = seen[i];
                    m_run[i]   = 0;
                    m_rose[i]  = seen[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_cyc = n;
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Watch n cycles, counting pulses and noting when each first appeared.
    task automatic watch(input int n, output int ne, output int nx, output int nr,
                         output logic [1:0] slot, output int fe, output int fx);
        ne = 0; nx = 0; nr = 0; slot = '0; fe = -1; fx = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.entry_signal) begin ne++; if (fe < 0) fe = k; end
            if (bus.exit_signal)  begin nx++; if (fx < 0) fx = k; slot = bus.exit_slot; end
            if (bus.reject) nr++;
        end
    endtask

    typedef struct {
        string      name;
        logic       ent;
        logic       ext;
        logic [1:0] sel;
        logic [3:0] spots;
        logic [2:0] cap;
        int         n_entry;
        int         n_exit;
        int         n_rej;
        logic [1:0] slot;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int ne, nx, nr, fe, fx;
        logic [1:0] slot;
        int hold_left [2];
        logic [1:0] lvl;
        logic exp_e, exp_x, exp_r, exp_b;
        logic [2:0] ce;

        vecs[0] = '{"entry_cap4",  1'b1, 1'b0, 2'd0, 4'b0000, 3'd4, 1, 0, 0, 2'd0};
        vecs[1] = '{"entry_full",  1'b1, 1'b0, 2'd0, 4'b1111, 3'd0, 0, 0, 1, 2'd0};
        vecs[2] = '{"entry_cap7",  1'b1, 1'b0, 2'd0, 4'b1111, 3'd7, 1, 0, 0, 2'd0};
        vecs[3] = '{"exit_slot2",  1'b0, 1'b1, 2'd2, 4'b1111, 3'd0, 0, 1, 0, 2'd2};
        vecs[4] = '{"exit_empty3", 1'b0, 1'b1, 2'd3, 4'b0001, 3'd3, 0, 0, 1, 2'd0};
        vecs[5] = '{"exit_slot0",  1'b0, 1'b1, 2'd0, 4'b0001, 3'd3, 0, 1, 0, 2'd0};
        vecs[6] = '{"entry_cap1",  1'b1, 1'b0, 2'd1, 4'b0111, 3'd1, 1, 0, 0, 2'd0};

        bus.entry_btn = 1'b0; bus.exit_btn = 1'b0; bus.exit_sel = 2'd0;
        bus.spots = 4'd0; bus.capacity = 3'd4;

        // Reset state
        #12;
        check("rst_entry", bus.entry_signal, 0);
        check("rst_exit",  bus.exit_signal, 0);
        check("rst_reject", bus.reject, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_slot",  bus.exit_slot, 0);

        // Entry press timing from reset release
        bus.entry_btn = 1'b1;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("timing_entry_e%0d", k), bus.entry_signal, (k == DEB + 4));
            check($sformatf("timing_busy_e%0d", k), bus.busy, (k >= DEB + 4 && k <= DEB + 4 + GAP));
            check($sformatf("timing_rej_e%0d", k), bus.reject, 0);
        end
        bus.entry_btn = 1'b0;
        repeat (20) @(negedge clk);

        // Vector table
        foreach (vecs[v]) begin
            bus.exit_sel = vecs[v].sel; bus.spots = vecs[v].spots; bus.capacity = vecs[v].cap;
            bus.entry_btn = vecs[v].ent; bus.exit_btn = vecs[v].ext;
            watch(20, ne, nx, nr, slot, fe, fx);
            check({vecs[v].name, "_entry"}, ne, vecs[v].n_entry);
            check({vecs[v].name, "_exit"},  nx, vecs[v].n_exit);
            check({vecs[v].name, "_rej"},   nr, vecs[v].n_rej);
            if (vecs[v].n_exit > 0) check({vecs[v].name, "_slot"}, slot, vecs[v].slot);
            bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
            repeat (20) @(negedge clk);
        end

        // Bounce rejection
        bus.capacity = 3'd4;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) bus.entry_btn = ~bus.entry_btn;
            @(negedge clk);
        end
        bus.entry_btn = 1'b0;
        watch(20, ne, nx, nr, slot, fe, fx);
        check("bounce_entry", ne, 0);
        check("bounce_rej", nr, 0);

        // Same-cycle entry and exit
        do_reset();
        bus.capacity = 3'd2; bus.spots = 4'b0011; bus.exit_sel = 2'd1;
        bus.entry_btn = 1'b1; bus.exit_btn = 1'b1;
        watch(30, ne, nx, nr, slot, fe, fx);
        check("tie1_counts", {ne[7:0], nx[7:0], nr[7:0]}, {8'd1, 8'd1, 8'd0});
        check("tie1_slot", slot, 1);
        check("tie1_spacing", fe - fx, GAP + 2);
        bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
        repeat (20) @(negedge clk);
        bus.entry_btn = 1'b1; bus.exit_btn = 1'b1;
        watch(30, ne, nx, nr, slot, fe, fx);
        check("tie2_counts", {ne[7:0], nx[7:0], nr[7:0]}, {8'd1, 8'd1, 8'd0});
`ifdef ALTERNATE_PRIO_EN
        check("tie2_spacing", fx - fe, GAP + 2);
`else
        check("tie2_spacing", fe - fx, GAP + 2);
`endif
        bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
        repeat (20) @(negedge clk);

        // Reset during HOLD with the button still held
        bus.capacity = 3'd4;
        bus.entry_btn = 1'b1;
        fe = -1;
        for (int k = 0; k < 20 && fe < 0; k++) begin
            @(negedge clk);
            if (bus.entry_signal) fe = k;
        end
        check("hold_first_pulse_seen", (fe >= 0), 1);
        @(negedge clk);
        check("hold_busy_before_reset", bus.busy, 1);
        #1 reset = 1'b0;
        #1;
        check("hold_rst_outs", {bus.entry_signal, bus.exit_signal, bus.reject, bus.exit_slot}, 0);
        check("hold_rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("hold_refire_e%0d", k), bus.entry_signal, (k == DEB + 4));
        end
        bus.entry_btn = 1'b0;
        repeat (20) @(negedge clk);

        // Randomized run against the reference model
        bus.entry_btn = 1'b0; bus.exit_btn = 1'b0;
        do_reset();
        hold_left[0] = 0; hold_left[1] = 0; lvl = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hold_left[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    hold_left[i] = $urandom_range(1, 14);
                end else begin
                    hold_left[i]--;
                end
            end
            bus.entry_btn = lvl[0]; bus.exit_btn = lvl[1];
            if ($urandom_range(0, 7) == 0) bus.exit_sel = 2'($urandom_range(0, 3));
            bus.spots = 4'($urandom);
            bus.capacity = 3'($urandom);
            @(negedge clk);
            ce    = (bus.capacity > 3'd4) ? 3'd4 : bus.capacity;
            exp_e = m_issuing && !m_chose_exit && (ce != 3'd0);
            exp_x = m_issuing && m_chose_exit && bus.spots[m_slot];
            exp_r = m_issuing && !exp_e && !exp_x;
            exp_b = m_issuing || (m_cyc < m_hold_end);
            check("rnd_entry",  bus.entry_signal, exp_e);
            check("rnd_exit",   bus.exit_signal, exp_x);
            check("rnd_reject", bus.reject, exp_r);
            check("rnd_busy",   bus.busy, exp_b);
            if (exp_x) check("rnd_slot", bus.exit_slot, m_slot);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_request_ctrl.md
Name: gate_request_ctrl

Overview:
Front-end request stage that sits directly upstream of the parking FSM. It synchronises and debounces the raw entry and exit push-buttons and edge-detects them. It then arbitrates between the two request types and checks each request against the FSM's occupancy feedback. It drives the FSM's entry_signal, exit_signal and exit_slot inputs as clean single-cycle pulses, spaced so the FSM's 2-cycle gate-open window completes before the next event.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to change a debounced level (range 1..255)
GAP_CYCLES, 3, hold-off cycles after each issued pulse or reject before the next arbitration (range 1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
entry_btn  input  1  raw entry button/sensor, asynchronous
exit_btn  input  1  raw exit button/sensor, asynchronous
exit_sel  input  2  slot chosen for exit, sampled when the debounced exit_btn rises
spots  input  4  occupancy from the FSM, 1 = occupied
capacity  input  3  remaining capacity from the FSM, 0..4
entry_signal  output  1  one-cycle entry pulse to the FSM
exit_signal  output  1  one-cycle exit pulse to the FSM
exit_slot  output  2  slot for exit_signal, held stable from ISSUE until the next exit issue
reject  output  1  one-cycle pulse when a request is refused
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: asynchronous, active-low (reset=0 clears immediately). All outputs are 0. Synchronisers, debounced levels, counters and pending flags are 0. State is IDLE.
- Reset mid-operation aborts any pulse or hold-off. After reset releases, a button still held high is seen as a new press, because the debounced level restarts at 0.
- Each button passes through a 2-flop synchroniser and then a per-button debounce counter.
  - The counter resets whenever the synchronised value equals the debounced level.
  - The debounced level flips once the synchronised value has differed for DEBOUNCE_CYCLES consecutive cycles.
- A debounced rising edge sets the pending flag for that request type. For an exit press, it also latches exit_sel into pend_slot.
- A new press of a type whose pending flag is already set is dropped.
- Timing from idle: with the button high before edge 1, debounced high registers at edge DEBOUNCE_CYCLES+2, pending at edge +3, and the pulse is high for the cycle after edge DEBOUNCE_CYCLES+4.
- State machine, IDLE -> ISSUE -> HOLD -> IDLE:
  - IDLE: if any request is pending, pick one (exit has priority) and go to ISSUE.
  - ISSUE, one cycle: validate the chosen request and output exactly one of entry_signal, exit_signal or reject. Clear the chosen pending flag. Load the hold counter with GAP_CYCLES.
  - HOLD: decrement the counter each cycle. When it reaches 0, return to IDLE. New presses still set pending flags during HOLD.
- Validation, using the values sampled in the ISSUE cycle:
  - An entry is refused if capacity==0.
  - An exit is refused if spots[pend_slot]==0.
  - capacity values above 4 are treated as 4.
- Simultaneous events:
  - Entry and exit edges in the same cycle both become pending and are issued in consecutive arbitration rounds.
  - An edge arriving in the ISSUE cycle is kept pending.
- Minimum spacing between any two output pulses is GAP_CYCLES+2 cycles.
- entry_signal and exit_signal are never high together.

Optional Feature:
ALTERNATE_PRIO_EN
- Defined: when both requests are pending in IDLE, the winner alternates using a 1-bit last_winner register. The register resets to "entry", so the first tie goes to exit. It updates only when a tie is arbitrated.
- Undefined: exit always wins ties. An entry can therefore starve while exits keep arriving.

Test Plan:
- Debounced entry: DEBOUNCE_CYCLES=4, capacity=4; hold entry_btn high from edge 1 -> entry_signal high for exactly one cycle, after edge 8; busy high for 1+GAP_CYCLES cycles.
- Bounce rejection: toggle entry_btn every 2 cycles for 20 cycles, then return low -> no entry_signal, no reject.
- Full lot: capacity=0, press entry -> reject pulse once, entry_signal stays 0; then press exit with exit_sel=2, spots=4'b1111 -> exit_signal pulses with exit_slot=2.
- Empty-slot exit: spots=4'b0001, exit_sel=3 -> reject pulse, exit_signal stays 0.
- Same-cycle entry and exit with GAP_CYCLES=3, capacity=2, spots=4'b0011, exit_sel=1 -> exit_signal (slot 1) first, then entry_signal exactly 5 cycles later. With ALTERNATE_PRIO_EN, a second tie issues entry first.
- Reset during HOLD: pull reset low for 1 cycle -> all outputs 0 immediately, busy=0; a still-held button yields a fresh pulse DEBOUNCE_CYCLES+4 edges after release.
